mac_unit: RTL and testbench

//  Multi-cycle multiply-accumulate responder for the custom MAC instruction in the Execute stage.
//  The IEU issues an operation with a valid/ready handshake. The block iterates a shift-add multiply.
//  It then returns Result = low XLEN bits of (A*B [+ Acc]) with a valid/ready handshake.
//  It holds a private architectural accumulator, Acc, which is updated only when a response is accepted.

---
 rtl/mac_unit_pkg.sv | 15 +
 rtl/mac_step.sv | 16 +
 rtl/mac_unit.sv | 106 ++++++++++
 tb/tb_mac_unit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_unit_pkg.sv
// mac_unit_pkg: shared configuration, opcode and state encodings for the MAC unit
package mac_unit_pkg;
  typedef struct packed {
    int XLEN;
  } cvw_t;
  localparam cvw_t CVW_DEFAULT = '{XLEN: 32};
  typedef enum logic [1:0] {
    MAC_MUL = 2'b00,
    MAC_MAC = 2'b01,
    MAC_CLR = 2'b10
  } mac_op_t;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
endpackage

// File: rtl/mac_step.sv
// mac_step: one shift-add iteration retiring BPC multiplier bits into the running product
module mac_step #(
  parameter int XLEN = 32,
  parameter int BPC  = 2
) (
  input  logic [XLEN-1:0] prod_i,
  input  logic [XLEN-1:0] mcand_i,
  input  logic [BPC-1:0]  mplier_i,
  output logic [XLEN-1:0] prod_o
);
  // add each selected, pre-shifted copy of the multiplicand; carries past XLEN are dropped
  always_comb begin
    prod_o = prod_i;
    for (int i = 0; i < BPC; i++) prod_o = prod_o + (mplier_i[i] ? mcand_i << i : '0);
  end
endmodule

// File: rtl/mac_unit.sv
// mac_unit: multi-cycle shift-add multiply-accumulate responder with a private accumulator
module mac_unit import mac_unit_pkg::*; #(
  parameter cvw_t P   = CVW_DEFAULT,
  parameter int   BPC = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              FlushE,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic [1:0]        Op,
  input  logic              W64,
  input  logic [P.XLEN-1:0] A,
  input  logic [P.XLEN-1:0] B,
  output logic              RespValid,
  input  logic              RespReady,
  output logic [P.XLEN-1:0] Result,
  output logic              Busy
);
  localparam int XLEN      = P.XLEN;
  localparam int MAC_ITERS = XLEN / BPC;
  localparam int CW        = $clog2(MAC_ITERS);
  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] mcand_q, mcand_d, mplier_q, mplier_d, prod_q, prod_d;
  logic [XLEN-1:0] acc_q, acc_d, res_q, res_d;
  logic            mac_q, mac_d, w64_q, w64_d;
  logic [XLEN-1:0] step_prod, sum, res_fmt;
  logic            accept;
  assign ReqReady  = state_q == S_IDLE;
  assign Busy      = state_q != S_IDLE;
  assign RespValid = state_q == S_DONE;
  assign Result    = res_q;
  assign accept    = ReqValid & ReqReady & ~FlushE;
  mac_step #(.XLEN(XLEN), .BPC(BPC)) u_step (
    .prod_i  (prod_q),
    .mcand_i (mcand_q),
    .mplier_i(mplier_q[BPC-1:0]),
    .prod_o  (step_prod)
  );
  // the final step's product feeds the result directly so DONE follows the last BUSY cycle
  assign sum     = step_prod + (mac_q ? acc_q : '0);
  assign res_fmt = (XLEN == 64 && w64_q) ? XLEN'($signed(sum[31:0])) : sum;
  // next-state: accept in IDLE, iterate in BUSY, commit Acc on the response handshake; flush wins
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    acc_d    = acc_q;
    res_d    = res_q;
    mac_d    = mac_q;
    w64_d    = w64_q;
    if (state_q == S_IDLE) begin
      if (accept) begin
        mcand_d  = A;
        mplier_d = B;
        prod_d   = '0;
        mac_d    = Op == MAC_MAC;
        w64_d    = W64;
        cnt_d    = CW'(MAC_ITERS - 1);
        state_d  = Op == MAC_CLR ? S_DONE : S_BUSY;
        if (Op == MAC_CLR) res_d = '0;
      end
    end else if (FlushE) begin
      state_d = S_IDLE;
    end else if (state_q == S_BUSY) begin
      prod_d   = step_prod;
      mcand_d  = mcand_q << BPC;
      mplier_d = mplier_q >> BPC;
      cnt_d    = cnt_q - CW'(1);
      if (cnt_q == '0) begin
        state_d = S_DONE;
        res_d   = res_fmt;
      end
    end else if (RespReady) begin
      state_d = S_IDLE;
      acc_d   = res_q;
    end
  end
  // state registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      acc_q    <= '0;
      res_q    <= '0;
      mac_q    <= 1'b0;
      w64_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      acc_q    <= acc_d;
      res_q    <= res_d;
      mac_q    <= mac_d;
      w64_q    <= w64_d;
    end
  end
endmodule

// File: tb/tb_mac_unit.sv
// tb_mac_unit: scenario tasks against an arithmetic reference model with a tracked accumulator
module tb_mac_unit;
  import mac_unit_pkg::*;
  localparam cvw_t CFG64 = '{XLEN: 64};
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0, req_valid = 1'b0, w64 = 1'b0, resp_ready = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic        req_ready, resp_valid, busy;
  logic [31:0] result;
  logic        flush64 = 1'b0, req64_valid = 1'b0, w64x = 1'b0, resp64_ready = 1'b0;
  logic [1:0]  op64 = 2'b00;
  logic [63:0] a64 = '0, b64 = '0;
  logic [2:0]  rr64, rv64, busy64;
  logic [63:0] res64 [3];
  int          checks = 0, errors = 0;
  logic [31:0] m_acc = '0;
  logic [63:0] m_acc64 = '0;

  always #5 clk = ~clk;

  mac_unit #(.P(CVW_DEFAULT), .BPC(2)) dut (
    .clk(clk), .resetn(resetn), .FlushE(flush), .ReqValid(req_valid), .ReqReady(req_ready),
    .Op(op), .W64(w64), .A(a), .B(b), .RespValid(resp_valid), .RespReady(resp_ready),
    .Result(result), .Busy(busy)
  );

  for (genvar g = 0; g < 3; g++) begin : g_x64
    mac_unit #(.P(CFG64), .BPC(1 << g)) u (
      .clk(clk), .resetn(resetn), .FlushE(flush64), .ReqValid(req64_valid), .ReqReady(rr64[g]),
      .Op(op64), .W64(w64x), .A(a64), .B(b64), .RespValid(rv64[g]), .RespReady(resp64_ready),
      .Result(res64[g]), .Busy(busy64[g])
    );
  end

  function automatic logic [63:0] model(input bit x64, input logic [1:0] o, input logic w,
                                        input logic [63:0] x, input logic [63:0] y, input logic [63:0] acc);
    logic [127:0] p;
    logic [63:0]  r;
    p = {64'b0, x} * {64'b0, y} + ((o == 2'b01) ? {64'b0, acc} : 128'b0);
    r = x64 ? p[63:0] : {32'b0, p[31:0]};
    if (o == 2'b10) r = '0;
    else if (x64 && w) r = {{32{r[31]}}, r[31:0]};
    return r;
  endfunction

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    int n = 0;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL issue_ready got %b want 1", req_ready);
    end
    op = o; a = x; b = y; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (resp_valid !== 1'b1) begin
      errors++; $display("FAIL resp_timeout got %b want 1", resp_valid);
    end
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL handshake_idle got rdy=%b vld=%b busy=%b want 1 0 0", req_ready, resp_valid, busy);
    end
  endtask

  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input int hold);
    logic [63:0] e;
    logic [31:0] exp_r;
    int lat, exp_lat;
    e = model(1'b0, o, 1'b0, {32'b0, x}, {32'b0, y}, {32'b0, m_acc});
    exp_r = e[31:0];
    exp_lat = (o == MAC_CLR) ? 1 : 17;
    issue(o, x, y);
    wait_resp(lat);
    checks++;
    if (lat != exp_lat) begin
      errors++; $display("FAIL latency op=%0d got %0d want %0d", o, lat, exp_lat);
    end
    checks++;
    if (result !== exp_r) begin
      errors++; $display("FAIL result op=%0d a=%h b=%h got %h want %h", o, x, y, result, exp_r);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
    end
    if (hold > 0) begin
      checks++;
      if (result !== exp_r || resp_valid !== 1'b1) begin
        errors++; $display("FAIL hold_result got %h vld=%b want %h 1", result, resp_valid, exp_r);
      end
    end
    handshake();
    m_acc = exp_r;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || resp_valid !== 1'b0 || result !== 32'h0) begin
      errors++; $display("FAIL reset_outputs got busy=%b vld=%b res=%h want 0 0 0", busy, resp_valid, result);
    end
    resetn = 1'b1;
    m_acc = '0;
    m_acc64 = '0;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b want 1", req_ready);
    end
  endtask

  task automatic test_mul_mac();
    do_op(MAC_MUL, 32'd7, 32'd6, 0);
    do_op(MAC_MAC, 32'd3, 32'd5, 0);
  endtask

  task automatic test_flush();
    int seen = 0;
    issue(MAC_MAC, 32'd1, 32'd1);
    repeat (4) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL flush_busy got rdy=%b vld=%b busy=%b want 1 0 0", req_ready, resp_valid, busy);
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (resp_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL flush_no_resp got %0d want 0", seen);
    end
    do_op(MAC_MAC, 32'd1, 32'd1, 0);
    flush = 1'b1; req_valid = 1'b1; op = MAC_MUL; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL flush_idle_block got busy=%b rdy=%b want 0 1", busy, req_ready);
    end
    issue(MAC_MUL, 32'd2, 32'd3);
    begin
      int lat;
      wait_resp(lat);
    end
    flush = 1'b1; resp_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL flush_done got vld=%b rdy=%b want 0 1", resp_valid, req_ready);
    end
    do_op(MAC_MAC, 32'd0, 32'd0, 0);
  endtask

  task automatic test_wrap();
    do_op(MAC_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
  endtask

  task automatic test_backpressure();
    logic [31:0] r0;
    int lat;
    issue(MAC_MUL, $urandom, $urandom);
    wait_resp(lat);
    r0 = result;
    req_valid = 1'b1; op = MAC_CLR;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (result !== r0 || resp_valid !== 1'b1 || req_ready !== 1'b0) begin
        errors++; $display("FAIL backpressure cyc=%0d got res=%h vld=%b rdy=%b want %h 1 0", i, result, resp_valid, req_ready, r0);
      end
    end
    req_valid = 1'b0;
    handshake();
    m_acc = r0;
    do_op(MAC_MAC, 32'd0, 32'd0, 0);
    do_op(MAC_CLR, $urandom, $urandom, 0);
    do_op(MAC_MAC, 32'd0, 32'd0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) do_op(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom_range(0, 2));
  endtask

  task automatic test_async_reset();
    do_op(MAC_MUL, 32'd3, 32'd3, 0);
    issue(MAC_MAC, 32'd5, 32'd7);
    repeat (3) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || resp_valid !== 1'b0 || result !== 32'h0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL async_reset got busy=%b vld=%b res=%h rdy=%b want 0 0 0 1", busy, resp_valid, result, req_ready);
    end
    @(negedge clk);
    resetn = 1'b1;
    m_acc = '0;
    m_acc64 = '0;
    @(posedge clk); #1;
    do_op(MAC_MAC, 32'd2, 32'd2, 0);
  endtask

  task automatic w64_op(input logic [1:0] o, input logic w, input logic [63:0] x, input logic [63:0] y);
    logic [63:0] e;
    int lat [3];
    e = model(1'b1, o, w, x, y, m_acc64);
    lat = '{0, 0, 0};
    op64 = o; w64x = w; a64 = x; b64 = y; req64_valid = 1'b1;
    @(posedge clk); #1;
    req64_valid = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      for (int g = 0; g < 3; g++) if (rv64[g] && lat[g] == 0) lat[g] = n;
      if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
      @(posedge clk); #1;
    end
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (lat[g] != 64 / (1 << g) + 1) begin
        errors++; $display("FAIL w64_latency bpc=%0d got %0d want %0d", 1 << g, lat[g], 64 / (1 << g) + 1);
      end
      checks++;
      if (res64[g] !== e) begin
        errors++; $display("FAIL w64_result bpc=%0d op=%0d w=%b got %h want %h", 1 << g, o, w, res64[g], e);
      end
    end
    resp64_ready = 1'b1;
    @(posedge clk); #1;
    resp64_ready = 1'b0;
    checks++;
    if (busy64 !== 3'b000 || rr64 !== 3'b111) begin
      errors++; $display("FAIL w64_idle got busy=%b rdy=%b want 000 111", busy64, rr64);
    end
    m_acc64 = e;
  endtask

  task automatic test_w64();
    w64_op(MAC_MUL, 1'b1, 64'h1_0000, 64'h8000);
    w64_op(MAC_MAC, 1'b0, {$urandom, $urandom}, {$urandom, $urandom});
    w64_op(MAC_MUL, 1'b1, {$urandom, $urandom}, {$urandom, $urandom});
    w64_op(MAC_MAC, 1'b1, {$urandom, $urandom}, {$urandom, $urandom});
  endtask

  initial begin
    test_reset();
    test_mul_mac();
    test_flush();
    test_wrap();
    test_backpressure();
    test_random();
    test_async_reset();
    test_w64();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
